presents_collision_manager: RTL and testbench
=============================================

PRESENTS_COLLISION_MANAGER -- requirements
Module: presents_collision_manager

Interface
REQ-001 Parameter NUM_PRESENTS, default 3: number of present channels, 1..16.
REQ-002 Parameter HOLDOFF_FRAMES, default 30: frames a reported present ignores further hits, 0..255.
REQ-003 Parameter CNT_W, default 8: width of the collected-presents counter.
REQ-004 clk  input  1  system clock; sole clock domain.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 startOfFrame  input  1  one-cycle pulse marking the frame boundary.
REQ-007 playerRequest  input  1  player sprite drawing the current pixel.
REQ-008 ropeRequest  input  1  rope sprite drawing the current pixel.
REQ-009 presentRequest  input  NUM_PRESENTS  bit i: present i drawing the current pixel.
REQ-010 clearCount  input  1  synchronous clear of collectCount.
REQ-011 col_player_present  output  NUM_PRESENTS  bit i: one-cycle pulse when player collects present i.
REQ-012 col_rope_present  output  NUM_PRESENTS  bit i: one-cycle pulse when rope hits present i.
REQ-013 anyCollision  output  1  OR of all bits of both pulse vectors, same cycle.
REQ-014 collectCount  output  CNT_W  saturating count of reported collisions.
REQ-015 presentBlocked  output  NUM_PRESENTS  bit i high while present i is in HOLDOFF.

Function
REQ-016 Each channel runs an independent FSM with states IDLE and HOLDOFF, plus two sticky flags, hitP and hitR, and a frame counter of ceil(log2(HOLDOFF_FRAMES+1)) bits, minimum 1 bit.
REQ-017 In IDLE, a cycle with playerRequest & presentRequest[i] high sets hitP[i], and a cycle with ropeRequest & presentRequest[i] high sets hitR[i]. In HOLDOFF, both flags stay clear.
REQ-018 Flags are evaluated only on startOfFrame; collisions are therefore reported at most once per frame per present.
REQ-019 On startOfFrame with channel i in IDLE and hitP[i]=1, col_player_present[i] pulses in the next cycle (latency 1), and col_rope_present[i] stays low: player has priority.
REQ-020 On startOfFrame with channel i in IDLE, hitP[i]=0 and hitR[i]=1, col_rope_present[i] pulses in the next cycle.
REQ-021 When a pulse is generated per REQ-019/020, the channel enters HOLDOFF with its counter loaded to HOLDOFF_FRAMES. If HOLDOFF_FRAMES=0, the channel stays in IDLE.
REQ-022 In HOLDOFF, each startOfFrame decrements the counter. When a decrement yields 0, the channel returns to IDLE on that edge.
REQ-023 Every startOfFrame clears hitP and hitR after evaluation. A present/sprite overlap in the same cycle as startOfFrame is attributed to the new frame: the flag is set after the clear if the channel is IDLE after the edge.
REQ-024 presentBlocked[i] = (state==HOLDOFF), registered.
REQ-025 collectCount adds the number of bits set across both pulse vectors in the pulse cycle (0..NUM_PRESENTS) and saturates at 2^CNT_W-1; it never wraps.
REQ-026 clearCount has priority over the increment: collectCount becomes 0 in the next cycle and that cycle's pulses are not counted.
REQ-027 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-028 resetN low asynchronously forces all channels to IDLE, flags and counters to 0, all pulse outputs, anyCollision, presentBlocked and collectCount to 0.
REQ-029 Reset asserted mid-frame or mid-HOLDOFF discards pending flags. After release, no pulse occurs until a new overlap is followed by startOfFrame.

Verification
REQ-030 NUM_PRESENTS=3, HOLDOFF_FRAMES=2: playerRequest & presentRequest=3'b010 for 5 cycles, then startOfFrame -> col_player_present=3'b010 for exactly 1 cycle, collectCount=1, presentBlocked=3'b010.
REQ-031 Same frame player and rope both overlap present 0 -> only col_player_present[0] pulses; col_rope_present=0; collectCount +1.
REQ-032 Present 1 in HOLDOFF, repeated overlaps for 2 frames -> no pulses. 3rd frame overlap plus startOfFrame -> pulse again; presentBlocked[1] falls on the 2nd startOfFrame.
REQ-033 Rope overlaps presents 0 and 2 in one frame -> col_rope_present=3'b101 in one cycle, collectCount +2, anyCollision=1 for one cycle.
REQ-034 CNT_W=2, 5 separate reported collisions -> collectCount sticks at 3. clearCount asserted in a pulse cycle -> 0.
REQ-035 resetN low while flags are set mid-frame, released before startOfFrame -> no pulse at that startOfFrame; all outputs 0.

Source files
------------

// File: rtl/presents_collision_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : presents_collision_manager_if
// Description : Frame/sprite request inputs and collision result outputs of
//               the presents collision manager, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface presents_collision_manager_if #(
  parameter int NUM_PRESENTS = 3,
  parameter int CNT_W        = 8
);
  logic                    startOfFrame;
  logic                    playerRequest;
  logic                    ropeRequest;
  logic [NUM_PRESENTS-1:0] presentRequest;
  logic                    clearCount;
  logic [NUM_PRESENTS-1:0] col_player_present;
  logic [NUM_PRESENTS-1:0] col_rope_present;
  logic                    anyCollision;
  logic [CNT_W-1:0]        collectCount;
  logic [NUM_PRESENTS-1:0] presentBlocked;

  // Video pipeline side: drives requests, observes results
  modport master (
    output startOfFrame, playerRequest, ropeRequest, presentRequest, clearCount,
    input  col_player_present, col_rope_present, anyCollision, collectCount,
           presentBlocked
  );

  // Collision manager side
  modport slave (
    input  startOfFrame, playerRequest, ropeRequest, presentRequest, clearCount,
    output col_player_present, col_rope_present, anyCollision, collectCount,
           presentBlocked
  );
endinterface
`default_nettype wire

// File: rtl/presents_collision_manager.sv
`default_nettype none
// ============================================================================
// Module      : presents_collision_manager
// Description : Per-present collision detection between player/rope sprites
//               and presents. Overlaps are latched during a frame, reported
//               once at the frame boundary (player wins over rope), then the
//               present is ignored for HOLDOFF_FRAMES frames. Reported
//               collisions are accumulated in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module presents_collision_manager #(
  parameter int NUM_PRESENTS   = 3,
  parameter int HOLDOFF_FRAMES = 30,
  parameter int CNT_W          = 8
) (
  input wire                            clk,
  input wire                            resetN,
  presents_collision_manager_if.slave   bus
);

  // Holdoff counter width: enough to hold HOLDOFF_FRAMES, never below 1 bit
  localparam int HCW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [HCW-1:0] C_HOLD_LOAD = HCW'(HOLDOFF_FRAMES);
  localparam logic [HCW-1:0] C_HOLD_ONE  = HCW'(1);

  // Sum width covers the counter plus up to 2*16 pulses in one cycle
  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] C_CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  logic [NUM_PRESENTS-1:0] w_col_p;
  logic [NUM_PRESENTS-1:0] w_col_r;
  logic [NUM_PRESENTS-1:0] w_blocked;

  genvar gi;
  for (gi = 0; gi < NUM_PRESENTS; gi++) begin : g_chan
    state_t         r_state, w_state_nxt;
    logic [HCW-1:0] r_cnt, w_cnt_nxt;
    logic           r_hit_p, w_hit_p_nxt;
    logic           r_hit_r, w_hit_r_nxt;
    logic           r_pulse_p, w_pulse_p_nxt;
    logic           r_pulse_r, w_pulse_r_nxt;
    logic           w_ov_p, w_ov_r;

    assign w_ov_p = bus.playerRequest & bus.presentRequest[gi];
    assign w_ov_r = bus.ropeRequest   & bus.presentRequest[gi];

    // Channel state, holdoff counter, sticky hit flags and pulse registers
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_hit_p   <= 1'b0;
        r_hit_r   <= 1'b0;
        r_pulse_p <= 1'b0;
        r_pulse_r <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_hit_p   <= w_hit_p_nxt;
        r_hit_r   <= w_hit_r_nxt;
        r_pulse_p <= w_pulse_p_nxt;
        r_pulse_r <= w_pulse_r_nxt;
      end
    end

    // Frame-boundary evaluation, holdoff countdown and overlap latching
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hit_p_nxt   = r_hit_p;
      w_hit_r_nxt   = r_hit_r;
      w_pulse_p_nxt = 1'b0;
      w_pulse_r_nxt = 1'b0;

      if (bus.startOfFrame) begin
        w_hit_p_nxt = 1'b0;
        w_hit_r_nxt = 1'b0;
        if (r_state == ST_IDLE) begin
          // Player takes priority when both sprites touched this present
          if (r_hit_p) begin
            w_pulse_p_nxt = 1'b1;
          end else if (r_hit_r) begin
            w_pulse_r_nxt = 1'b1;
          end
          // A zero holdoff keeps the channel permanently in IDLE
          if ((r_hit_p || r_hit_r) && (HOLDOFF_FRAMES != 0)) begin
            w_state_nxt = ST_HOLDOFF;
            w_cnt_nxt   = C_HOLD_LOAD;
          end
        end else begin
          if (r_cnt <= C_HOLD_ONE) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - C_HOLD_ONE;
          end
        end
      end

      // Overlaps only count while the channel will be IDLE; an overlap on the
      // boundary cycle belongs to the new frame, hence applied after clearing
      if (w_state_nxt == ST_IDLE) begin
        if (w_ov_p) w_hit_p_nxt = 1'b1;
        if (w_ov_r) w_hit_r_nxt = 1'b1;
      end
    end

    assign w_col_p[gi]   = r_pulse_p;
    assign w_col_r[gi]   = r_pulse_r;
    assign w_blocked[gi] = (r_state == ST_HOLDOFF);
  end

  logic [SUM_W-1:0] w_hits;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] r_count;

  // Number of pulses reported in the current cycle across both vectors
  always_comb begin
    w_hits = '0;
    for (int k = 0; k < NUM_PRESENTS; k++) begin
      w_hits = w_hits + SUM_W'(w_col_p[k]) + SUM_W'(w_col_r[k]);
    end
  end

  assign w_sum = SUM_W'(r_count) + w_hits;

  // Saturating collision counter; clear wins over the increment
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (bus.clearCount) begin
      r_count <= '0;
    end else if (w_sum > C_CNT_MAX) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  // All outputs come straight from flops
  assign bus.col_player_present = w_col_p;
  assign bus.col_rope_present   = w_col_r;
  assign bus.anyCollision       = (|w_col_p) | (|w_col_r);
  assign bus.collectCount       = r_count;
  assign bus.presentBlocked     = w_blocked;

endmodule
`default_nettype wire

// File: tb/tb_presents_collision_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_presents_collision_manager
// Description : Directed bench for presents_collision_manager. Instance A
//               uses an 8-bit counter, instance B a 2-bit counter to exercise
//               saturation; both see identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_presents_collision_manager;

  logic clk;
  logic resetN;
  int   n_checks;
  int   n_errors;

  presents_collision_manager_if #(.NUM_PRESENTS(3), .CNT_W(8)) bus_a ();
  presents_collision_manager_if #(.NUM_PRESENTS(3), .CNT_W(2)) bus_b ();

  assign bus_b.startOfFrame   = bus_a.startOfFrame;
  assign bus_b.playerRequest  = bus_a.playerRequest;
  assign bus_b.ropeRequest    = bus_a.ropeRequest;
  assign bus_b.presentRequest = bus_a.presentRequest;
  assign bus_b.clearCount     = bus_a.clearCount;

  presents_collision_manager #(
    .NUM_PRESENTS(3), .HOLDOFF_FRAMES(2), .CNT_W(8)
  ) dut_a (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_a.slave)
  );

  presents_collision_manager #(
    .NUM_PRESENTS(3), .HOLDOFF_FRAMES(2), .CNT_W(2)
  ) dut_b (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] cp, input logic [2:0] cr,
                         input logic any, input logic [2:0] blk);
    chk({tag, ".col_player"}, 32'(bus_a.col_player_present), 32'(cp));
    chk({tag, ".col_rope"},   32'(bus_a.col_rope_present),   32'(cr));
    chk({tag, ".any"},        32'(bus_a.anyCollision),       32'(any));
    chk({tag, ".blocked"},    32'(bus_a.presentBlocked),     32'(blk));
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] ea, input logic [1:0] eb);
    chk({tag, ".count_a"}, 32'(bus_a.collectCount), 32'(ea));
    chk({tag, ".count_b"}, 32'(bus_b.collectCount), 32'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic r, input logic [2:0] pr);
    bus_a.playerRequest  = p;
    bus_a.ropeRequest    = r;
    bus_a.presentRequest = pr;
  endtask

  // Hold an overlap for n cycles, then release the sprites
  task automatic overlap(input logic p, input logic r, input logic [2:0] pr, input int n);
    drive(p, r, pr);
    repeat (n) tick();
    drive(1'b0, 1'b0, 3'b000);
  endtask

  // One-cycle frame boundary; returns in the pulse cycle
  task automatic frame_sof();
    bus_a.startOfFrame = 1'b1;
    tick();
    bus_a.startOfFrame = 1'b0;
    drive(1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetN   = 1'b0;
    bus_a.startOfFrame = 1'b0;
    bus_a.clearCount   = 1'b0;
    drive(1'b0, 1'b0, 3'b000);

    // Reset state
    repeat (2) tick();
    chk_out("reset", 3'b000, 3'b000, 1'b0, 3'b000);
    chk_cnt("reset", 8'd0, 2'd0);
    resetN = 1'b1;
    tick();

    // Player on present 1 for 5 cycles
    overlap(1'b1, 1'b0, 3'b010, 5);
    frame_sof();
    chk_out("player_p1", 3'b010, 3'b000, 1'b1, 3'b010);
    tick();
    chk_out("player_p1_after", 3'b000, 3'b000, 1'b0, 3'b010);
    chk_cnt("player_p1", 8'd1, 2'd1);

    // Player and rope on present 0 in the same frame: player wins
    overlap(1'b1, 1'b1, 3'b001, 3);
    frame_sof();
    chk_out("prio", 3'b001, 3'b000, 1'b1, 3'b011);
    tick();
    chk_cnt("prio", 8'd2, 2'd2);

    // Overlap present 1 during holdoff: ignored, holdoff ends on this edge
    overlap(1'b1, 1'b0, 3'b010, 3);
    frame_sof();
    chk_out("holdoff_ignore", 3'b000, 3'b000, 1'b0, 3'b001);
    tick();
    chk_cnt("holdoff_ignore", 8'd2, 2'd2);

    // Present 1 free again; rope touches present 0 on the boundary cycle
    overlap(1'b1, 1'b0, 3'b010, 2);
    drive(1'b0, 1'b1, 3'b001);
    frame_sof();
    chk_out("p1_again", 3'b010, 3'b000, 1'b1, 3'b010);
    tick();
    chk_cnt("p1_again", 8'd3, 2'd3);

    // Boundary-cycle rope overlap reported at the following frame
    frame_sof();
    chk_out("sof_overlap", 3'b000, 3'b001, 1'b1, 3'b011);
    tick();
    chk_cnt("sof_overlap", 8'd4, 2'd3);

    // Two empty frames let all holdoffs expire
    frame_sof();
    chk_out("expire1", 3'b000, 3'b000, 1'b0, 3'b001);
    frame_sof();
    chk_out("expire2", 3'b000, 3'b000, 1'b0, 3'b000);

    // Rope on presents 0 and 2
    overlap(1'b0, 1'b1, 3'b101, 3);
    frame_sof();
    chk_out("rope_02", 3'b000, 3'b101, 1'b1, 3'b101);
    tick();
    chk_out("rope_02_after", 3'b000, 3'b000, 1'b0, 3'b101);
    chk_cnt("rope_02", 8'd6, 2'd3);

    // clearCount during a pulse cycle drops that pulse
    overlap(1'b1, 1'b0, 3'b010, 2);
    frame_sof();
    chk_out("clr_pulse", 3'b010, 3'b000, 1'b1, 3'b111);
    bus_a.clearCount = 1'b1;
    tick();
    bus_a.clearCount = 1'b0;
    chk_cnt("clear", 8'd0, 2'd0);
    tick();
    chk_cnt("clear_hold", 8'd0, 2'd0);

    // Asynchronous reset mid-holdoff
    resetN = 1'b0;
    #2;
    chk_out("async_rst", 3'b000, 3'b000, 1'b0, 3'b000);
    tick();
    resetN = 1'b1;
    tick();

    // Reset while flags are pending: no pulse at the next boundary
    overlap(1'b1, 1'b0, 3'b111, 2);
    resetN = 1'b0;
    #2;
    chk_out("rst_pending", 3'b000, 3'b000, 1'b0, 3'b000);
    tick();
    resetN = 1'b1;
    tick();
    frame_sof();
    chk_out("no_pulse_after_rst", 3'b000, 3'b000, 1'b0, 3'b000);
    tick();
    chk_cnt("no_pulse_after_rst", 8'd0, 2'd0);

    // Fresh overlap after reset works normally
    overlap(1'b0, 1'b1, 3'b100, 2);
    frame_sof();
    chk_out("post_rst", 3'b000, 3'b100, 1'b1, 3'b100);
    tick();
    chk_cnt("post_rst", 8'd1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
